// File: rtl/bist_session_ctrl.sv
// Session sequencer for the BIST datapath: engine reset, vector load over valid/ready,
// repeated runs under a per-run watchdog, and pass/fail verdict capture.
`timescale 1ns/1ps
module bist_session_ctrl #(
  parameter int unsigned RES_CYC   = 4,
  parameter int unsigned TIMEOUT   = 1023,
  parameter logic [3:0]  MODE_IDLE = 4'h0,
  parameter logic [3:0]  MODE_LOAD = 4'h1,
  parameter logic [3:0]  MODE_RUN  = 4'h2,
  parameter logic [3:0]  DONE_CODE = 4'hA
) (
  input  logic        clk_50MHz,
  input  logic        res,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  vec_cnt,
  input  logic [7:0]  loop_cnt,
  input  logic        load_valid,
  input  logic [11:0] load_data,
  output logic        load_ready,
  output logic        bist_clk_en,
  output logic        bist_res,
  output logic [15:0] bist_ctrl,
  input  logic [15:0] bist_stat,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_code,
  output logic [7:0]  fail_loop,
  output logic        timeout
);

  typedef enum logic [2:0] {
    StIdle, StEres, StLoad, StRun, StCheck, StNext, StFin
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  vec_q, vec_d;
  logic [7:0]  loops_q, loops_d;
  logic [7:0]  xfer_q, xfer_d;
  logic [7:0]  loop_idx_q, loop_idx_d;
  logic [3:0]  res_cnt_q, res_cnt_d;
  logic [9:0]  wd_q, wd_d;
  logic        pass_q, pass_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  err_code_q, err_code_d;
  logic [7:0]  fail_loop_q, fail_loop_d;

  logic unused_stat;
  assign unused_stat = ^bist_stat[10:8];

  always_ff @(posedge clk_50MHz or negedge res) begin
    if (!res) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      loops_q     <= '0;
      xfer_q      <= '0;
      loop_idx_q  <= '0;
      res_cnt_q   <= '0;
      wd_q        <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_code_q  <= '0;
      fail_loop_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      loops_q     <= loops_d;
      xfer_q      <= xfer_d;
      loop_idx_q  <= loop_idx_d;
      res_cnt_q   <= res_cnt_d;
      wd_q        <= wd_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_code_q  <= err_code_d;
      fail_loop_q <= fail_loop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    loops_d     = loops_q;
    xfer_d      = xfer_q;
    loop_idx_d  = loop_idx_q;
    res_cnt_d   = res_cnt_q;
    wd_d        = wd_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_code_d  = err_code_q;
    fail_loop_d = fail_loop_q;
    bist_ctrl   = {MODE_IDLE, 12'h000};
    load_ready  = 1'b0;
    bist_clk_en = 1'b0;
    bist_res    = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          vec_d       = vec_cnt;
          loops_d     = (loop_cnt == 8'd0) ? 8'd1 : loop_cnt;
          xfer_d      = '0;
          loop_idx_d  = '0;
          res_cnt_d   = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          err_code_d  = '0;
          fail_loop_d = '0;
          state_d     = StEres;
        end
      end
      StEres: begin
        bist_res    = 1'b1;
        bist_clk_en = 1'b1;
        if (res_cnt_q == 4'(RES_CYC - 1)) begin
          res_cnt_d = '0;
          wd_d      = '0;
          // Pattern memory survives engine reset, so only the first run loads.
          state_d   = (vec_q != 8'd0 && loop_idx_q == 8'd0) ? StLoad : StRun;
        end else begin
          res_cnt_d = res_cnt_q + 4'd1;
        end
      end
      StLoad: begin
        bist_ctrl   = {MODE_LOAD, load_data};
        load_ready  = 1'b1;
        bist_clk_en = load_valid;
        if (load_valid) begin
          xfer_d = xfer_q + 8'd1;
          if (xfer_q + 8'd1 == vec_q) begin
            wd_d    = '0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        bist_ctrl   = {MODE_RUN, 12'h000};
        bist_clk_en = 1'b1;
        if (bist_stat[15:12] == DONE_CODE) begin
          state_d = StCheck;
        end else if (wd_q == 10'(TIMEOUT)) begin
          timeout_d   = 1'b1;
          fail_loop_d = loop_idx_q;
          state_d     = StFin;
        end else begin
          wd_d = wd_q + 10'd1;
        end
      end
      StCheck: begin
        if (bist_stat[11]) begin
          err_code_d  = bist_stat[7:0];
          fail_loop_d = loop_idx_q;
          state_d     = StFin;
        end else begin
          state_d = StNext;
        end
      end
      StNext: begin
        loop_idx_d = loop_idx_q + 8'd1;
        if (loop_idx_d == loops_q) begin
          pass_d  = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StEres;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort outranks every other transition and leaves recorded results untouched.
    if (abort && state_q != StIdle && state_q != StFin) begin
      state_d     = StFin;
      pass_d      = pass_q;
      timeout_d   = timeout_q;
      err_code_d  = err_code_q;
      fail_loop_d = fail_loop_q;
    end
  end

  assign busy      = (state_q != StIdle);
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_code  = err_code_q;
  assign fail_loop = fail_loop_q;

endmodule
